// File: rtl/mips_enc_pkg.sv
// Shared constants for the MIPS instruction encoder: mnemonic codes,
// opcode/func fields and the output FSM state type.
package mips_enc_pkg;

  localparam logic [4:0] C_NOP     = 5'd0;
  localparam logic [4:0] C_ADD     = 5'd1;
  localparam logic [4:0] C_SUB     = 5'd2;
  localparam logic [4:0] C_AND     = 5'd3;
  localparam logic [4:0] C_OR      = 5'd4;
  localparam logic [4:0] C_XOR     = 5'd5;
  localparam logic [4:0] C_SLL     = 5'd6;
  localparam logic [4:0] C_SRL     = 5'd7;
  localparam logic [4:0] C_SRA     = 5'd8;
  localparam logic [4:0] C_JR      = 5'd9;
  localparam logic [4:0] C_HAMMING = 5'd10;
  localparam logic [4:0] C_ADDI    = 5'd11;
  localparam logic [4:0] C_ANDI    = 5'd12;
  localparam logic [4:0] C_ORI     = 5'd13;
  localparam logic [4:0] C_XORI    = 5'd14;
  localparam logic [4:0] C_LW      = 5'd15;
  localparam logic [4:0] C_SW      = 5'd16;
  localparam logic [4:0] C_BEQ     = 5'd17;
  localparam logic [4:0] C_BNE     = 5'd18;
  localparam logic [4:0] C_LUI     = 5'd19;
  localparam logic [4:0] C_J       = 5'd20;
  localparam logic [4:0] C_JAL     = 5'd21;
  localparam logic [4:0] C_LI      = 5'd22;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNC_ADD     = 6'b100000;
  localparam logic [5:0] FUNC_SUB     = 6'b100010;
  localparam logic [5:0] FUNC_AND     = 6'b100100;
  localparam logic [5:0] FUNC_OR      = 6'b100101;
  localparam logic [5:0] FUNC_XOR     = 6'b100110;
  localparam logic [5:0] FUNC_HAMMING = 6'b110001;
  localparam logic [5:0] FUNC_SLL     = 6'b000000;
  localparam logic [5:0] FUNC_SRL     = 6'b000010;
  localparam logic [5:0] FUNC_SRA     = 6'b000011;
  localparam logic [5:0] FUNC_JR      = 6'b001000;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    FULL_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/mips_word_pack.sv
// Combinational packer: mnemonic code plus fields to one machine word,
// applying the per-format field forcing. LI is only flagged here.
module mips_word_pack
  import mips_enc_pkg::*;
(
  input  logic [4:0]  code,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        is_li,
  output logic        illegal
);

  function automatic logic [31:0] r_word(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                         input logic [4:0] f_rd, input logic [4:0] f_sh,
                                         input logic [5:0] func);
    return {OP_RTYPE, f_rs, f_rt, f_rd, f_sh, func};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] f_rs,
                                         input logic [4:0] f_rt, input logic [15:0] f_imm);
    return {op, f_rs, f_rt, f_imm};
  endfunction

  always_comb begin
    word    = 32'h0000_0000;
    is_li   = 1'b0;
    illegal = 1'b0;
    case (code)
      C_NOP:     word = 32'h0000_0000;
      C_ADD:     word = r_word(rs, rt, rd, 5'd0, FUNC_ADD);
      C_SUB:     word = r_word(rs, rt, rd, 5'd0, FUNC_SUB);
      C_AND:     word = r_word(rs, rt, rd, 5'd0, FUNC_AND);
      C_OR:      word = r_word(rs, rt, rd, 5'd0, FUNC_OR);
      C_XOR:     word = r_word(rs, rt, rd, 5'd0, FUNC_XOR);
      C_HAMMING: word = r_word(rs, rt, rd, 5'd0, FUNC_HAMMING);
      C_SLL:     word = r_word(5'd0, rt, rd, shamt, FUNC_SLL);
      C_SRL:     word = r_word(5'd0, rt, rd, shamt, FUNC_SRL);
      C_SRA:     word = r_word(5'd0, rt, rd, shamt, FUNC_SRA);
      C_JR:      word = r_word(rs, 5'd0, 5'd0, 5'd0, FUNC_JR);
      C_ADDI:    word = i_word(OP_ADDI, rs, rt, imm[15:0]);
      C_ANDI:    word = i_word(OP_ANDI, rs, rt, imm[15:0]);
      C_ORI:     word = i_word(OP_ORI, rs, rt, imm[15:0]);
      C_XORI:    word = i_word(OP_XORI, rs, rt, imm[15:0]);
      C_LW:      word = i_word(OP_LW, rs, rt, imm[15:0]);
      C_SW:      word = i_word(OP_SW, rs, rt, imm[15:0]);
      C_BEQ:     word = i_word(OP_BEQ, rs, rt, imm[15:0]);
      C_BNE:     word = i_word(OP_BNE, rs, rt, imm[15:0]);
      C_LUI:     word = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
      C_J:       word = {OP_J, imm[25:0]};
      C_JAL:     word = {OP_JAL, imm[25:0]};
      C_LI:      is_li = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Symbolic-instruction to machine-word encoder with a one-word output
// register, LI expansion into lui/ori and a running byte address.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_code,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  state_t      state;
  logic [31:0] pend_word;
  logic [31:0] packed_word;
  logic        is_li;
  logic        illegal;
  logic        accept;
  logic [15:0] li_hi;
  logic [15:0] li_lo;

  mips_word_pack u_pack (
    .code    (in_code),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .word    (packed_word),
    .is_li   (is_li),
    .illegal (illegal)
  );

  assign li_hi     = in_imm[31:16];
  assign li_lo     = in_imm[15:0];
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      EMPTY:     in_ready = 1'b1;
      FULL:      in_ready = out_ready;
      default:   in_ready = 1'b0;
    endcase
  end

  // An illegal accept falls through to the no-accept path so a held word still drains.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      out_word  <= 32'h0000_0000;
      out_addr  <= ADDR_W'(BASE_ADDR);
      pend_word <= 32'h0000_0000;
      err       <= 1'b0;
    end else begin
      err <= accept & illegal;
      if (out_valid && out_ready)
        out_addr <= out_addr + ADDR_W'(4);
      case (state)
        EMPTY, FULL: begin
          if (accept && !illegal) begin
            state <= FULL;
            if (!is_li) begin
              out_word <= packed_word;
            end else if (li_hi != 16'h0000 && li_lo != 16'h0000) begin
              out_word  <= {OP_LUI, 5'd0, in_rt, li_hi};
              pend_word <= {OP_ORI, in_rt, in_rt, li_lo};
              state     <= FULL_PEND;
            end else if (li_hi == 16'h0000) begin
              out_word <= {OP_ORI, 5'd0, in_rt, li_lo};
            end else begin
              out_word <= {OP_LUI, 5'd0, in_rt, li_hi};
            end
          end else if (state == FULL && out_ready) begin
            state <= EMPTY;
          end
        end
        FULL_PEND: begin
          if (out_ready) begin
            out_word <= pend_word;
            state    <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
